// File: rtl/intra_pred_pkg.sv
// Shared types and defaults for the intra-prediction SAD path and its mode decider.
package intra_pred_pkg;

  localparam int unsigned DEF_PIX_W     = 8;
  localparam int unsigned DEF_NUM_MODES = 8;
  localparam int unsigned DEF_MB_SIZE_L = 8;
  localparam int unsigned DEF_MB_SIZE_W = 8;

  // Width that holds (2^pix_w - 1) * n_pix without overflow.
  function automatic int unsigned sad_width(input int unsigned pix_w, input int unsigned n_pix);
    return pix_w + $clog2(n_pix);
  endfunction

  localparam int unsigned DEF_SAD_W = sad_width(DEF_PIX_W, DEF_MB_SIZE_L * DEF_MB_SIZE_W);

  typedef logic [DEF_PIX_W-1:0] pix_t;
  typedef logic [DEF_SAD_W-1:0] sad_t;

  typedef enum logic [0:0] {
    ACCUM,
    OUT
  } state_t;

endpackage

// File: rtl/abs_diff.sv
// Combinational absolute difference |a - b| of two unsigned pixels.
module abs_diff
  import intra_pred_pkg::*;
#(
  parameter int unsigned PIX_W = DEF_PIX_W
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W:0]   y
);

  logic [PIX_W:0] diff;

  // Subtract one bit wider so the MSB flags a negative result, then negate it back.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b};
    y    = diff[PIX_W] ? -diff : diff;
  end

endmodule

// File: rtl/intra_sad_accumulator.sv
// Per-mode SAD accumulation over one macroblock, handing the finished vector to the decider.
module intra_sad_accumulator
  import intra_pred_pkg::*;
#(
  parameter int unsigned MB_SIZE_L = DEF_MB_SIZE_L,
  parameter int unsigned MB_SIZE_W = DEF_MB_SIZE_W,
  parameter int unsigned NUM_MODES = DEF_NUM_MODES,
  parameter int unsigned PIX_W     = DEF_PIX_W,
  localparam int unsigned N        = MB_SIZE_L * MB_SIZE_W,
  localparam int unsigned SAD_W    = sad_width(PIX_W, N),
  localparam int unsigned CNT_W    = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           orig_pix,
  input  logic [NUM_MODES*PIX_W-1:0] pred_pix,
  output logic                       sad_valid,
  input  logic                       sad_ready,
  output logic [NUM_MODES*SAD_W-1:0] sads,
  output logic [CNT_W-1:0]           pix_cnt
);

  state_t                     state_q, state_d;
  logic                       live_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [SAD_W-1:0]           acc_q [NUM_MODES];
  logic [SAD_W-1:0]           sum   [NUM_MODES];
  logic [PIX_W:0]             ad    [NUM_MODES];
  logic [NUM_MODES*SAD_W-1:0] sads_q;
  logic                       accept;
  logic                       last_beat;

  for (genvar m = 0; m < NUM_MODES; m++) begin : g_abs
    abs_diff #(
      .PIX_W(PIX_W)
    ) u_abs_diff (
      .a(orig_pix),
      .b(pred_pix[m*PIX_W +: PIX_W]),
      .y(ad[m])
    );
  end

  // Running sums including the beat currently on the inputs.
  always_comb begin
    for (int m = 0; m < NUM_MODES; m++) begin
      sum[m] = acc_q[m] + SAD_W'(ad[m]);
    end
  end

  // in_ready is only high in ACCUM, so an accepted beat never lands in OUT.
  always_comb begin
    accept    = in_valid && in_ready;
    last_beat = accept && (cnt_q == CNT_W'(N - 1));
  end

  // State register; live_q keeps in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next state: flush wins over both handshakes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (!flush && last_beat) state_d = OUT;
      OUT:   if (flush || sad_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Outputs decode from registered state only, so no ready/valid combinational paths.
  always_comb begin
    in_ready  = live_q && (state_q == ACCUM);
    sad_valid = (state_q == OUT);
    sads      = sads_q;
    pix_cnt   = cnt_q;
  end

  // Accumulators, beat counter and the held SAD vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
      cnt_q  <= '0;
      sads_q <= '0;
    end else if (flush) begin
      for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
      cnt_q  <= '0;
      sads_q <= '0;
    end else if (accept) begin
      for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= sum[m];
      if (last_beat) begin
        cnt_q <= '0;
        for (int m = 0; m < NUM_MODES; m++) sads_q[m*SAD_W +: SAD_W] <= sum[m];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (sad_valid && sad_ready) begin
      for (int m = 0; m < NUM_MODES; m++) acc_q[m] <= '0;
    end
  end

endmodule

// File: doc/intra_sad_accumulator.md
Name: intra_sad_accumulator

Overview:
- Stage directly upstream of the intra-prediction mode decider.
- Streams one macroblock's original pixels, plus the matching candidate prediction pixel for every intra mode.
- Accumulates the sum of absolute differences (SAD) per mode and presents the complete per-mode SAD vector with a valid/ready handshake for the decider's min-search.
- Processes one macroblock at a time, with back-pressure on both sides.

Parameters:
- MB_SIZE_L, 8, macroblock rows.
- MB_SIZE_W, 8, macroblock columns.
- NUM_MODES, 8, number of candidate intra modes, one SAD each.
- PIX_W, 8, pixel bit width.
- SAD_W, PIX_W + $clog2(MB_SIZE_L*MB_SIZE_W), SAD accumulator width (14 at defaults); derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: discard the partial macroblock and return to ACCUM.
- in_valid  in  1  pixel beat valid.
- in_ready  out  1  stage can accept a beat.
- orig_pix  in  PIX_W  original pixel, raster order within the macroblock.
- pred_pix  in  NUM_MODES*PIX_W  predicted pixel per mode; mode m occupies bits [m*PIX_W +: PIX_W].
- sad_valid  out  1  SAD vector complete and held.
- sad_ready  in  1  decider accepts the vector.
- sads  out  NUM_MODES*SAD_W  SAD per mode; mode m occupies bits [m*SAD_W +: SAD_W].
- pix_cnt  out  $clog2(MB_SIZE_L*MB_SIZE_W)  beats accepted in the current macroblock (debug/status).

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to ACCUM.
  - All accumulators, sads and pix_cnt go to 0.
  - sad_valid=0, in_ready=0 while reset is asserted.
  - in_ready=1 from the first clock after deassertion.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready at a rising edge.
  - On acceptance, for each m: acc[m] <= acc[m] + |orig_pix - pred_pix[m]|.
  - The difference is computed unsigned, PIX_W+1 bits wide, then magnitude taken.
  - The accumulator cannot overflow: the maximum is (2^PIX_W-1)*N, where N = MB_SIZE_L*MB_SIZE_W; the sum is zero-extended to SAD_W.
- States:
  - ACCUM:
    - in_ready=1, sad_valid=0.
    - pix_cnt increments per accepted beat.
    - On the accepted beat with pix_cnt==N-1: the sads register is loaded with the final sums (including that beat), pix_cnt wraps to 0, and the next state is OUT.
  - OUT:
    - in_ready=0, sad_valid=1.
    - sads is held stable until the handshake.
    - When sad_valid && sad_ready: accumulators clear to 0 and the next state is ACCUM. in_ready=1 on the following cycle; there is no bubble beyond that one cycle.
- Latency: sad_valid rises on the clock edge that accepts the last beat, i.e. it is visible in the following cycle.
- in_valid is ignored in OUT. Upstream must hold its beat, which is legal because in_ready=0.
- flush:
  - In ACCUM: accumulators and pix_cnt go to 0 and the state stays ACCUM. A beat presented in the same cycle is dropped.
  - In OUT: sad_valid drops, the vector is discarded, and the state goes to ACCUM with cleared accumulators.
  - flush takes priority over both handshakes in the same cycle.
- sads is only guaranteed meaningful while sad_valid=1. Outside OUT it holds the last loaded value or 0 after reset/flush.
- Reset asserted mid-macroblock: partial sums are lost, with no output pulse.
- No combinational path from sad_ready to in_ready, and none from in_valid to sad_valid.

Decomposition:
- Package intra_pred_pkg holds:
  - default PIX_W, NUM_MODES, MB_SIZE_L, MB_SIZE_W;
  - function sad_width(pix_w, n_pix);
  - typedef pix_t, logic [PIX_W-1:0];
  - typedef sad_t, logic [SAD_W-1:0];
  - enum state_t {ACCUM, OUT}.
- The decider imports the same package so that sad_t matches.
- Sub-module abs_diff: combinational |a-b| for PIX_W operands, instantiated NUM_MODES times in a generate loop.
- Accumulators, counter and FSM live in the top module.

Test Plan:
- Reset then 64 beats: orig=100, pred[m]=100+m for every beat, sad_ready=1 → a single sad_valid pulse; sads[m]=64*m (0,64,…,448); in_ready low for exactly one cycle.
- Worst case: orig=255, pred[0]=0, pred[others]=255 for 64 beats → sads[0]=16320 (no overflow), other sads=0.
- Back-pressure: complete a macroblock with sad_ready=0 for 10 cycles while in_valid=1 → sad_valid and sads held stable, in_ready=0, pix_cnt=0; after sad_ready=1 the next macroblock's first beat is accepted one cycle later.
- Random in_valid gaps (~50% duty), two back-to-back macroblocks with random pixels → both SAD vectors match the reference-model sums in order, with exactly two sad_valid pulses.
- flush after 30 beats, then a full 64-beat macroblock of orig=10, pred[m]=0 → the first 30 beats are excluded; sads[m]=640 for all m.
- Assert reset while in OUT with sad_ready=0 → sad_valid drops asynchronously and sads=0; after release, in_ready=1 and a fresh macroblock produces correct sums.
